// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arbiter_pkg
//   Shared types and constants for the instruction/data SRAM arbiter.
//   - ADDR_W / DATA_W / WEB_W : SRAM word-address, data and byte-enable widths
//   - WEB_READ                : active-low byte enables meaning "read"
//   - resp_owner_e            : which port owns the read response next cycle
//   - is_read()               : classifies a web pattern as a read
// ---------------------------------------------------------------------------
package mem_arbiter_pkg;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;
    localparam int WEB_W  = 4;

    localparam logic [WEB_W-1:0] WEB_READ = 4'hF;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [WEB_W-1:0]  web_t;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_IF   = 2'd1,
        RESP_DM   = 2'd2
    } resp_owner_e;

    function automatic logic is_read(input web_t web);
        return web == WEB_READ;
    endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// ---------------------------------------------------------------------------
// mem_arb_prio
//   Grant logic and starvation counter for the two-port SRAM arbiter.
//   DM wins a conflict unless IF has lost STARVE_MAX conflicts in a row,
//   in which case IF is forced through. Grants are combinational.
//
//   Parameter STARVE_MAX : consecutive DM conflict wins before IF is forced
//                          (legal range 1..7, counter is 3 bits)
//   Ports
//     clk, rst_n   : clock, asynchronous active-low reset
//     if_req_i     : instruction-fetch request
//     dm_req_i     : data request
//     if_gnt_o     : IF granted this cycle
//     dm_gnt_o     : DM granted this cycle
// ---------------------------------------------------------------------------
module mem_arb_prio #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic if_req_i,
    input  logic dm_req_i,
    output logic if_gnt_o,
    output logic dm_gnt_o
);

    localparam logic [2:0] STARVE_LIMIT = 3'(STARVE_MAX);

    logic [2:0] starve_cnt_q;
    logic [2:0] starve_cnt_d;
    logic       if_forced;

    always_comb begin
        if_forced    = (starve_cnt_q == STARVE_LIMIT);
        if_gnt_o     = 1'b0;
        dm_gnt_o     = 1'b0;
        starve_cnt_d = starve_cnt_q;

        // Grants are masked while reset is asserted so they drop immediately.
        if (rst_n) begin
            if (dm_req_i && !(if_req_i && if_forced)) begin
                dm_gnt_o = 1'b1;
            end else if (if_req_i) begin
                if_gnt_o = 1'b1;
            end
        end

        // The counter only tracks an unbroken run of IF losses.
        if (!if_req_i || if_gnt_o) begin
            starve_cnt_d = 3'd0;
        end else if (dm_gnt_o && (starve_cnt_q < STARVE_LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= 3'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Arbitrates one single-port SRAM between an instruction-fetch port (IF,
//   read only) and a data port (DM, read/write). One grant per cycle, grants
//   combinational, read data returns exactly one cycle after the grant.
//
//   Optional feature: define MEM_ARB_PERF_EN to add saturating performance
//   counters perf_conflict_cnt and perf_if_stall_cnt.
//
//   Ports
//     clk, rst_n                      : clock, asynchronous active-low reset
//     if_req/if_addr                  : fetch request and word address
//     if_gnt/if_rvalid/if_rdata       : fetch grant, response strobe, data
//     dm_req/dm_web/dm_addr/dm_wdata  : data request, active-low byte enables
//                                       (4'hF = read), address, store data
//     dm_gnt/dm_rvalid/dm_rdata       : data grant, response strobe, data
//     SRAM_CS/OE/WEB/A/DI             : SRAM control, address and write data
//     SRAM_DO                         : SRAM read data (one cycle after address)
//     perf_conflict_cnt               : cycles with both requests high
//     perf_if_stall_cnt               : cycles with if_req high and no if_gnt
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic [WEB_W-1:0]  dm_web,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              SRAM_CS,
    output logic              SRAM_OE,
    output logic [WEB_W-1:0]  SRAM_WEB,
    output logic [ADDR_W-1:0] SRAM_A,
    output logic [DATA_W-1:0] SRAM_DI,
    input  logic [DATA_W-1:0] SRAM_DO
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_conflict_cnt,
    output logic [31:0]       perf_if_stall_cnt
`endif
);

    addr_t       sram_a_q;
    addr_t       sram_a_d;
    resp_owner_e resp_owner_q;
    resp_owner_e resp_owner_d;
    data_t       if_rdata_q;
    data_t       dm_rdata_q;

    mem_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req_i (if_req),
        .dm_req_i (dm_req),
        .if_gnt_o (if_gnt),
        .dm_gnt_o (dm_gnt)
    );

    // SRAM request mux. The address register keeps the last granted address
    // on idle cycles; web/di/oe fall back to their idle values.
    always_comb begin
        SRAM_WEB     = WEB_READ;
        SRAM_OE      = 1'b0;
        SRAM_DI      = '0;
        sram_a_d     = sram_a_q;
        resp_owner_d = RESP_NONE;
        if (if_gnt) begin
            sram_a_d     = if_addr;
            SRAM_OE      = 1'b1;
            resp_owner_d = RESP_IF;
        end else if (dm_gnt) begin
            sram_a_d = dm_addr;
            SRAM_WEB = dm_web;
            SRAM_DI  = dm_wdata;
            // Writes finish in the grant cycle and never produce a response.
            if (is_read(dm_web)) begin
                SRAM_OE      = 1'b1;
                resp_owner_d = RESP_DM;
            end
        end
    end

    assign SRAM_A  = sram_a_d;
    // Chip select follows reset directly so it drops the moment reset asserts.
    assign SRAM_CS = rst_n;

    // Response side: SRAM_DO is forwarded in the response cycle and captured
    // so rdata holds between responses.
    assign if_rvalid = (resp_owner_q == RESP_IF);
    assign dm_rvalid = (resp_owner_q == RESP_DM);
    assign if_rdata  = if_rvalid ? SRAM_DO : if_rdata_q;
    assign dm_rdata  = dm_rvalid ? SRAM_DO : dm_rdata_q;

    // Resetting resp_owner discards any read in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_a_q     <= '0;
            resp_owner_q <= RESP_NONE;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
        end else begin
            sram_a_q     <= sram_a_d;
            resp_owner_q <= resp_owner_d;
            if (if_rvalid) begin
                if_rdata_q <= SRAM_DO;
            end
            if (dm_rvalid) begin
                dm_rdata_q <= SRAM_DO;
            end
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_conflict_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_conflict_q <= '0;
            perf_stall_q    <= '0;
        end else begin
            if (if_req && dm_req && (perf_conflict_q != 32'hFFFF_FFFF)) begin
                perf_conflict_q <= perf_conflict_q + 32'd1;
            end
            if (if_req && !if_gnt && (perf_stall_q != 32'hFFFF_FFFF)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_conflict_cnt = perf_conflict_q;
    assign perf_if_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter (STARVE_MAX = 4). Inputs are driven 1 ns
//   after the rising edge and outputs are sampled 2 ns after it.
//   Define MEM_ARB_PERF_EN to also exercise the performance counters.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req;
    logic [13:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic [3:0]  dm_web;
    logic [13:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        SRAM_CS;
    logic        SRAM_OE;
    logic [3:0]  SRAM_WEB;
    logic [13:0] SRAM_A;
    logic [31:0] SRAM_DI;
    logic [31:0] SRAM_DO;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_conflict_cnt;
    logic [31:0] perf_if_stall_cnt;
`endif

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .STARVE_MAX (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_web    (dm_web),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_gnt    (dm_gnt),
        .dm_rvalid (dm_rvalid),
        .dm_rdata  (dm_rdata),
        .SRAM_CS   (SRAM_CS),
        .SRAM_OE   (SRAM_OE),
        .SRAM_WEB  (SRAM_WEB),
        .SRAM_A    (SRAM_A),
        .SRAM_DI   (SRAM_DI),
        .SRAM_DO   (SRAM_DO)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_conflict_cnt (perf_conflict_cnt),
        .perf_if_stall_cnt (perf_if_stall_cnt)
`endif
    );

    task automatic test_reset();
        // Requests active during reset must not produce grants.
        if_req   = 1'b1;
        if_addr  = 14'h3FFF;
        dm_req   = 1'b1;
        dm_web   = 4'h0;
        dm_addr  = 14'h1234;
        dm_wdata = 32'hFFFF_FFFF;
        SRAM_DO  = 32'h5555_5555;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if ({if_gnt, dm_gnt, if_rvalid, dm_rvalid} !== 4'b0000)
            $display("FAIL reset_strobes: got %b expected 0000", {if_gnt, dm_gnt, if_rvalid, dm_rvalid});
        else passes++;
        checks++;
        if ({if_rdata, dm_rdata} !== 64'h0)
            $display("FAIL reset_rdata: got %h expected 0", {if_rdata, dm_rdata});
        else passes++;
        checks++;
        if ({SRAM_CS, SRAM_OE, SRAM_WEB} !== 6'b00_1111)
            $display("FAIL reset_sram_ctl: got %b expected 001111", {SRAM_CS, SRAM_OE, SRAM_WEB});
        else passes++;
        checks++;
        if ({SRAM_A, SRAM_DI} !== 46'h0)
            $display("FAIL reset_sram_a_di: got %h expected 0", {SRAM_A, SRAM_DI});
        else passes++;
`ifdef MEM_ARB_PERF_EN
        checks++;
        if ({perf_conflict_cnt, perf_if_stall_cnt} !== 64'h0)
            $display("FAIL reset_perf: got %h expected 0", {perf_conflict_cnt, perf_if_stall_cnt});
        else passes++;
`endif
        if_req = 1'b0;
        dm_req = 1'b0;
        dm_web = 4'hF;
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        checks++;
        if ({SRAM_CS, SRAM_OE, SRAM_WEB, if_gnt, dm_gnt} !== 8'b10_1111_00)
            $display("FAIL post_reset_idle: got %b expected 10111100", {SRAM_CS, SRAM_OE, SRAM_WEB, if_gnt, dm_gnt});
        else passes++;
    endtask

    task automatic test_if_read();
        @(posedge clk);
        #1;
        if_req  = 1'b1;
        if_addr = 14'h0010;
        SRAM_DO = 32'h0000_0013;
        #1;
        checks++;
        if ({if_gnt, dm_gnt} !== 2'b10)
            $display("FAIL if_read_gnt: got %b expected 10", {if_gnt, dm_gnt});
        else passes++;
        checks++;
        if ({SRAM_A, SRAM_OE, SRAM_WEB} !== {14'h0010, 1'b1, 4'hF})
            $display("FAIL if_read_sram: got a=%h oe=%b web=%h expected a=0010 oe=1 web=f", SRAM_A, SRAM_OE, SRAM_WEB);
        else passes++;
        @(posedge clk);
        #1 if_req = 1'b0;
        #1;
        checks++;
        if ({if_rvalid, dm_rvalid} !== 2'b10)
            $display("FAIL if_read_rvalid: got %b expected 10", {if_rvalid, dm_rvalid});
        else passes++;
        checks++;
        if (if_rdata !== 32'h0000_0013)
            $display("FAIL if_read_rdata: got %h expected 00000013", if_rdata);
        else passes++;
        checks++;
        if ({SRAM_A, SRAM_OE, if_gnt} !== {14'h0010, 1'b0, 1'b0})
            $display("FAIL if_read_idle_hold: got a=%h oe=%b gnt=%b expected a=0010 oe=0 gnt=0", SRAM_A, SRAM_OE, if_gnt);
        else passes++;
        @(posedge clk);
        #1 SRAM_DO = 32'hDEAD_BEEF;
        #1;
        checks++;
        if ({if_rvalid, if_rdata} !== {1'b0, 32'h0000_0013})
            $display("FAIL if_rdata_hold: got rvalid=%b rdata=%h expected 0/00000013", if_rvalid, if_rdata);
        else passes++;
    endtask

    task automatic test_dm_write();
        @(posedge clk);
        #1;
        dm_req   = 1'b1;
        dm_web   = 4'b1110;
        dm_addr  = 14'h0100;
        dm_wdata = 32'h0000_00AB;
        #1;
        checks++;
        if ({if_gnt, dm_gnt} !== 2'b01)
            $display("FAIL dm_write_gnt: got %b expected 01", {if_gnt, dm_gnt});
        else passes++;
        checks++;
        if ({SRAM_WEB, SRAM_A, SRAM_DI, SRAM_OE} !== {4'b1110, 14'h0100, 32'h0000_00AB, 1'b0})
            $display("FAIL dm_write_sram: got web=%b a=%h di=%h oe=%b expected 1110/0100/000000ab/0", SRAM_WEB, SRAM_A, SRAM_DI, SRAM_OE);
        else passes++;
        @(posedge clk);
        #1;
        dm_req = 1'b0;
        dm_web = 4'hF;
        #1;
        checks++;
        if ({if_rvalid, dm_rvalid, dm_rdata} !== {2'b00, 32'h0})
            $display("FAIL dm_write_no_rvalid: got rvalid=%b rdata=%h expected 00/0", {if_rvalid, dm_rvalid}, dm_rdata);
        else passes++;
        checks++;
        if ({SRAM_A, SRAM_DI, SRAM_WEB} !== {14'h0100, 32'h0, 4'hF})
            $display("FAIL dm_write_idle: got a=%h di=%h web=%h expected 0100/0/f", SRAM_A, SRAM_DI, SRAM_WEB);
        else passes++;
    endtask

    task automatic test_starve();
        // Bit i = 1 means IF wins cycle i of a continuous conflict.
        logic [9:0] exp_if_pat;
        logic [31:0] exp_data;
        exp_if_pat = 10'b10_0001_0000;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) begin
                if_req  = 1'b1;
                if_addr = 14'h0040;
                dm_req  = 1'b1;
                dm_web  = 4'hF;
                dm_addr = 14'h0200;
            end
            exp_data = 32'hA000_0000 + 32'(i);
            SRAM_DO  = exp_data;
            #1;
            checks++;
            if ({if_gnt, dm_gnt} !== {exp_if_pat[i], ~exp_if_pat[i]})
                $display("FAIL starve_gnt[%0d]: got %b expected %b", i, {if_gnt, dm_gnt}, {exp_if_pat[i], ~exp_if_pat[i]});
            else passes++;
            checks++;
            if (SRAM_A !== (exp_if_pat[i] ? 14'h0040 : 14'h0200))
                $display("FAIL starve_addr[%0d]: got %h expected %h", i, SRAM_A, exp_if_pat[i] ? 14'h0040 : 14'h0200);
            else passes++;
            if (i > 0) begin
                checks++;
                if ({if_rvalid, dm_rvalid} !== {exp_if_pat[i-1], ~exp_if_pat[i-1]})
                    $display("FAIL starve_rvalid[%0d]: got %b expected %b", i, {if_rvalid, dm_rvalid}, {exp_if_pat[i-1], ~exp_if_pat[i-1]});
                else passes++;
                checks++;
                if ((exp_if_pat[i-1] ? if_rdata : dm_rdata) !== exp_data)
                    $display("FAIL starve_rdata[%0d]: got %h expected %h", i, exp_if_pat[i-1] ? if_rdata : dm_rdata, exp_data);
                else passes++;
            end
        end
        @(posedge clk);
        #1;
        if_req  = 1'b0;
        dm_req  = 1'b0;
        SRAM_DO = 32'hA000_000A;
        #1;
        checks++;
        if ({if_rvalid, dm_rvalid, if_rdata} !== {2'b10, 32'hA000_000A})
            $display("FAIL starve_last_resp: got rvalid=%b rdata=%h expected 10/a000000a", {if_rvalid, dm_rvalid}, if_rdata);
        else passes++;
`ifdef MEM_ARB_PERF_EN
        checks++;
        if (perf_conflict_cnt !== 32'd10)
            $display("FAIL perf_conflict: got %0d expected 10", perf_conflict_cnt);
        else passes++;
        checks++;
        if (perf_if_stall_cnt !== 32'd8)
            $display("FAIL perf_if_stall: got %0d expected 8", perf_if_stall_cnt);
        else passes++;
`endif
    endtask

    task automatic test_back_to_back();
        // Bit i = 1: IF read in cycle i, otherwise DM read.
        logic [5:0]  alt_if;
        logic [31:0] exp_data;
        alt_if = 6'b01_0101;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            if (i < 6) begin
                if_req  = alt_if[i];
                dm_req  = ~alt_if[i];
                if_addr = 14'h0020 + 14'(i);
                dm_addr = 14'h0300 + 14'(i);
                dm_web  = 4'hF;
            end else begin
                if_req = 1'b0;
                dm_req = 1'b0;
            end
            exp_data = 32'hB000_0000 + 32'(i);
            SRAM_DO  = exp_data;
            #1;
            if (i < 6) begin
                checks++;
                if ({if_gnt, dm_gnt, SRAM_OE} !== {alt_if[i], ~alt_if[i], 1'b1})
                    $display("FAIL b2b_gnt[%0d]: got %b expected %b", i, {if_gnt, dm_gnt, SRAM_OE}, {alt_if[i], ~alt_if[i], 1'b1});
                else passes++;
            end
            if (i > 0) begin
                checks++;
                if ({if_rvalid, dm_rvalid} !== {alt_if[i-1], ~alt_if[i-1]})
                    $display("FAIL b2b_rvalid[%0d]: got %b expected %b", i, {if_rvalid, dm_rvalid}, {alt_if[i-1], ~alt_if[i-1]});
                else passes++;
                checks++;
                if ((alt_if[i-1] ? if_rdata : dm_rdata) !== exp_data)
                    $display("FAIL b2b_rdata[%0d]: got %h expected %h", i, alt_if[i-1] ? if_rdata : dm_rdata, exp_data);
                else passes++;
            end
        end
        @(posedge clk);
        #2;
        checks++;
        if ({if_rvalid, dm_rvalid} !== 2'b00)
            $display("FAIL b2b_pulse_end: got %b expected 00", {if_rvalid, dm_rvalid});
        else passes++;
        checks++;
        if ({if_rdata, dm_rdata} !== {32'hB000_0005, 32'hB000_0006})
            $display("FAIL b2b_rdata_hold: got %h/%h expected b0000005/b0000006", if_rdata, dm_rdata);
        else passes++;
    endtask

    task automatic test_reset_inflight();
        @(posedge clk);
        #1;
        dm_req  = 1'b1;
        dm_web  = 4'hF;
        dm_addr = 14'h0200;
        SRAM_DO = 32'hC0DE_0001;
        #1;
        checks++;
        if ({dm_gnt, SRAM_A} !== {1'b1, 14'h0200})
            $display("FAIL inflight_gnt: got gnt=%b a=%h expected 1/0200", dm_gnt, SRAM_A);
        else passes++;
        @(posedge clk);
        #1;
        if_req = 1'b1;
        rst_n  = 1'b0;
        #1;
        checks++;
        if ({if_gnt, dm_gnt, if_rvalid, dm_rvalid} !== 4'b0000)
            $display("FAIL inflight_rst_strobes: got %b expected 0000", {if_gnt, dm_gnt, if_rvalid, dm_rvalid});
        else passes++;
        checks++;
        if ({if_rdata, dm_rdata} !== 64'h0)
            $display("FAIL inflight_rst_rdata: got %h expected 0", {if_rdata, dm_rdata});
        else passes++;
        checks++;
        if ({SRAM_CS, SRAM_OE, SRAM_WEB, SRAM_A, SRAM_DI} !== {2'b00, 4'hF, 14'h0, 32'h0})
            $display("FAIL inflight_rst_sram: got cs=%b oe=%b web=%h a=%h di=%h expected 0/0/f/0/0", SRAM_CS, SRAM_OE, SRAM_WEB, SRAM_A, SRAM_DI);
        else passes++;
        // Release reset with IF requesting: the grant is available at once.
        @(posedge clk);
        #1;
        dm_req  = 1'b0;
        if_addr = 14'h0077;
        rst_n   = 1'b1;
        #1;
        checks++;
        if ({if_gnt, dm_gnt, dm_rvalid, SRAM_A} !== {3'b100, 14'h0077})
            $display("FAIL post_rst_first_gnt: got gnt=%b rv=%b a=%h expected 10/0/0077", {if_gnt, dm_gnt}, dm_rvalid, SRAM_A);
        else passes++;
        @(posedge clk);
        #1;
        if_req  = 1'b0;
        SRAM_DO = 32'h0000_0777;
        #1;
        checks++;
        if ({if_rvalid, dm_rvalid, if_rdata, dm_rdata} !== {2'b10, 32'h0000_0777, 32'h0})
            $display("FAIL post_rst_resp: got rv=%b if=%h dm=%h expected 10/00000777/0", {if_rvalid, dm_rvalid}, if_rdata, dm_rdata);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_dm_write();
        test_starve();
        test_back_to_back();
        test_reset_inflight();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: STARVE_MAX, default 4, meaning the number of consecutive DM wins during an IF conflict before IF is forced a grant (legal range 1..7).
REQ-002 Ports (clock and reset first):
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_req  in  1  instruction-fetch read request.
- if_addr  in  14  word address of the fetch.
- if_gnt  out  1  fetch accepted this cycle.
- if_rvalid  out  1  if_rdata valid this cycle.
- if_rdata  out  32  fetched word.
- dm_req  in  1  data request.
- dm_web  in  4  active-low byte write enables; 4'hF means read.
- dm_addr  in  14  data word address.
- dm_wdata  in  32  store data, already byte-lane aligned.
- dm_gnt  out  1  data request accepted this cycle.
- dm_rvalid  out  1  dm_rdata valid this cycle.
- dm_rdata  out  32  loaded word.
- SRAM_CS  out  1  SRAM chip select.
- SRAM_OE  out  1  SRAM output enable.
- SRAM_WEB  out  4  SRAM active-low byte write enables.
- SRAM_A  out  14  SRAM word address.
- SRAM_DI  out  32  SRAM write data.
- SRAM_DO  in  32  SRAM read data, valid one cycle after the address is presented.
REQ-003 The block SHALL use one clock, clk, with an asynchronous, active-low reset, rst_n.

Function
REQ-004 The block SHALL grant at most one requester per cycle; if_gnt and dm_gnt SHALL be combinational in the request cycle and never high together.
REQ-005 Priority SHALL be: DM wins a conflict unless starve_cnt == STARVE_MAX, in which case IF wins.
REQ-006 starve_cnt (3 bits) SHALL increment when DM is granted while if_req is high. It SHALL clear when IF is granted or when if_req is low. It SHALL never exceed STARVE_MAX.
REQ-007 The granted requester's address, web and wdata SHALL drive SRAM_A, SRAM_WEB and SRAM_DI combinationally in the grant cycle.
REQ-008 With no grant: SRAM_WEB = 4'hF, SRAM_OE = 0, SRAM_A holds its last value, SRAM_DI = 0.
REQ-009 SRAM_OE SHALL be 1 in any cycle with a granted read. SRAM_CS SHALL be 1 whenever out of reset.
REQ-010 Read latency SHALL be exactly 1 cycle:
- A registered resp_owner (NONE/IF/DM) SHALL select which rvalid pulses in the next cycle.
- That rvalid SHALL be high for exactly one cycle, with rdata = SRAM_DO.
REQ-011 A DM write (dm_web != 4'hF) SHALL complete in the grant cycle and SHALL produce no dm_rvalid.
REQ-012 The rdata output of a port SHALL hold its last value while its rvalid is low.
REQ-013 Back-to-back grants SHALL be allowed every cycle. A response and a new grant SHALL be able to coincide.
REQ-014 A requester SHALL hold its req, addr, web and wdata stable until it is granted; the block SHALL NOT queue requests.

Reset
REQ-015 When rst_n is asserted, the block SHALL immediately set the following:
- if_gnt, dm_gnt, if_rvalid, dm_rvalid = 0
- if_rdata, dm_rdata = 0
- SRAM_CS = 0, SRAM_OE = 0, SRAM_WEB = 4'hF
- SRAM_A = 0, SRAM_DI = 0
- starve_cnt = 0, resp_owner = NONE
REQ-016 A read in flight when reset asserts SHALL be discarded; no rvalid SHALL follow reset deassertion.
REQ-017 Grants SHALL first be possible in the first rising edge cycle after rst_n deasserts.

Configuration
REQ-018 With MEM_ARB_PERF_EN defined, the block SHALL add these outputs:
- perf_conflict_cnt [31:0]: counts cycles in which if_req and dm_req are both high.
- perf_if_stall_cnt [31:0]: counts cycles in which if_req is high and if_gnt is low.
- Both counters saturate at 32'hFFFF_FFFF and reset to 0.
REQ-019 Without MEM_ARB_PERF_EN, these ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-020 The shared package SHALL hold:
- the RESP_OWNER enum (NONE/IF/DM)
- WEB_READ = 4'hF
- the address and data width constants, reused from the core's shared typedefs
REQ-021 One sub-module is natural: mem_arb_prio, containing the starve counter and grant logic. The response/SRAM mux SHALL stay in the top level.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- if_req only, if_addr = 14'h0010, SRAM_DO = 32'h0000_0013: if_gnt same cycle; if_rvalid = 1 with if_rdata = 32'h0000_0013 next cycle.
- dm_req with dm_web = 4'b1110, dm_addr = 14'h0100, dm_wdata = 32'h0000_00AB: SRAM_WEB = 4'b1110, SRAM_A = 14'h0100, SRAM_DI = 32'h0000_00AB that cycle; no dm_rvalid.
- if_req and dm_req (read) both held continuously, STARVE_MAX = 4: DM granted 4 cycles, IF granted on the 5th, and the pattern repeats.
- Alternating IF and DM reads every cycle: each rvalid is a single-cycle pulse with the correct owner and data; the two rvalids are never high together.
- rst_n asserted the cycle after a DM read grant: no dm_rvalid follows; all outputs match REQ-015 immediately.
- MEM_ARB_PERF_EN defined, 10 cycles of continuous conflict: perf_conflict_cnt = 10 and perf_if_stall_cnt = 8 with STARVE_MAX = 4.
